joy_db15_tx: RTL and testbench
==============================

JOY_DB15_TX -- requirements
Module: joy_db15_tx

Interface
REQ-001 The block SHALL use one clock and an asynchronous, active-high reset: clk (40-50 MHz joystick clock domain) and reset.
REQ-002 Parameter SYNC_STAGES, default 2: synchronizer depth on joy_clk and joy_load, in the range 2..4.
REQ-003 Parameter TIMEOUT_CYCLES, default 2_500_000: clk cycles without a completed frame before host_active drops (50 ms at 50 MHz).
REQ-004 Ports SHALL be:
- clk  in  1  system clock.
- reset  in  1  async active-high reset.
- joy1  in  12  player 1 buttons, active-high, layout LS FEDCBAUDLR (bit0=R).
- joy2  in  12  player 2 buttons, same layout.
- joy_load  in  1  host latch strobe, active-low, asynchronous to clk.
- joy_clk  in  1  host shift clock, asynchronous to clk.
- joy_data  out  1  serial data to host, active-low (pressed=0), idle 1.
- frame_done  out  1  one-cycle pulse when the 24th bit has been shifted.
- host_active  out  1  high while frames arrive within TIMEOUT_CYCLES.

Function
REQ-005 joy_load and joy_clk SHALL pass through SYNC_STAGES flip-flops before use; all edge detection uses the synchronized signals.
REQ-006 The frame SHALL be 24 bits, shifted out LSB first: bits 0-11 = ~joy1[11:0], bits 12-23 = ~joy2[11:0].
REQ-007 FSM states: IDLE, LOAD, SHIFT, DONE; reset state IDLE.
REQ-008 IDLE: joy_data=1; synchronized joy_load low -> LOAD.
REQ-009 LOAD: the shift register reloads from ~{joy2,joy1} every cycle; joy_data = shift register bit0; bit counter = 0; synchronized joy_load high -> SHIFT, freezing the snapshot taken on the last LOAD cycle.
REQ-010 SHIFT: each synchronized joy_clk rising edge SHALL shift the register right by one, fill with 1, and increment the counter; joy_data = bit0.
REQ-011 SHIFT: on the edge that brings the counter to 24, the FSM SHALL go to DONE, pulse frame_done for one cycle, and drive joy_data to 1.
REQ-012 DONE: joy_data=1; further joy_clk edges are ignored; joy_load low -> LOAD.
REQ-013 joy_load low SHALL take priority in every state: any joy_clk edge in the same cycle is ignored and the FSM goes to LOAD, which aborts a partial frame without a frame_done pulse.
REQ-014 A joy_clk edge seen in IDLE or LOAD SHALL be ignored.
REQ-015 Latency: joy_data SHALL reflect the new bit no later than SYNC_STAGES+1 clk cycles after the raw joy_clk rising edge. The host shift clock half-period must be at least SYNC_STAGES+2 clk cycles.
REQ-016 The counter is 5 bits, saturates at 24 and does not wrap.
REQ-017 Watchdog: a counter reloads to 0 on frame_done and otherwise counts up, saturating at TIMEOUT_CYCLES.
REQ-018 host_active SHALL be 1 when frame_done occurs and SHALL go to 0 when the watchdog counter reaches TIMEOUT_CYCLES.
REQ-019 joy_data SHALL be driven from a register, glitch-free.

Reset
REQ-020 While reset is asserted: FSM=IDLE, shift register all 1, counter=0, synchronizers=1, joy_data=1, frame_done=0, host_active=0, watchdog=0.
REQ-021 Reset asserted mid-frame SHALL abort the frame immediately (asynchronously), with no frame_done pulse; after release the FSM waits in IDLE for a fresh joy_load low.

Structure
REQ-022 A shared package joy_db15_pkg SHALL hold FRAME_BITS=24, BTN_BITS=12, the per-bit button index constants, and the FSM state enum, shared with the joy_db15 receiver.
REQ-023 One sub-module, db15_sync_edge (synchronizer plus rise/fall detector, parameterized by SYNC_STAGES), SHALL be instantiated twice.

Verification
REQ-024 The bench SHALL cover the following directed scenarios:
- Normal frame: joy1=12'h001, joy2=12'h800; load pulse, then 24 clocks. joy_data sequence = 0, then 22 ones, then a final 0; frame_done pulses once; joy_data=1 afterwards.
- Abort: joy_load pulled low again after 10 clocks, with new joy1=12'h002. The next frame's bit1=0 and no frame_done occurs for the aborted frame.
- Simultaneous: joy_clk rises in the same synchronized cycle as joy_load falls. The FSM is in LOAD, the counter stays 0, and no shift occurs.
- Overrun: 30 clocks after the load. Exactly one frame_done; joy_data=1 for clocks 25-30.
- Watchdog: TIMEOUT_CYCLES=100, one frame followed by silence. host_active=1 after frame_done and 0 exactly 100 cycles later.
- Reset at clock 12 of a frame. joy_data=1 immediately; after release, joy_clk edges do nothing until the next load.

Source files
------------

// File: rtl/joy_db15_pkg.sv
// Shared definitions for the DB15 joystick serial link (transmitter and receiver).
// Frame geometry, button bit positions within a 12-bit player word, FSM states.
// Button layout per player, MSB..LSB: L S F E D C B A U D L R (bit0 = Right).
package joy_db15_pkg;

  localparam int FRAME_BITS = 24;
  localparam int BTN_BITS   = 12;
  localparam int CNT_BITS   = 5;

  // Bit positions inside one player's 12-bit button word
  localparam int BTN_RIGHT  = 0;
  localparam int BTN_LEFT   = 1;
  localparam int BTN_DOWN   = 2;
  localparam int BTN_UP     = 3;
  localparam int BTN_A      = 4;
  localparam int BTN_B      = 5;
  localparam int BTN_C      = 6;
  localparam int BTN_D      = 7;
  localparam int BTN_E      = 8;
  localparam int BTN_F      = 9;
  localparam int BTN_S      = 10;
  localparam int BTN_L      = 11;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_LOAD  = 2'd1,
    ST_SHIFT = 2'd2,
    ST_DONE  = 2'd3
  } db15_state_t;

  // Wire-level frame: active-low buttons, player 1 in the low half (sent first)
  function automatic logic [FRAME_BITS-1:0] frame_word(
    input logic [BTN_BITS-1:0] p1,
    input logic [BTN_BITS-1:0] p2
  );
    return ~{p2, p1};
  endfunction

endpackage

// File: rtl/db15_sync_edge.sv
// Multi-flop synchronizer for one asynchronous host signal plus edge detection.
// Rise/fall pulses are one clk cycle wide and aligned with the synchronized level.
// Flops reset to 1 so an idle (high) line produces no spurious edge after reset.
module db15_sync_edge
  import joy_db15_pkg::*;
#(
  parameter int SYNC_STAGES = 2
) (
  input  logic clk,
  input  logic reset,
  input  logic din,
  output logic dout,
  output logic rise,
  output logic fall
);

  logic [SYNC_STAGES-1:0] sync_q;
  logic [SYNC_STAGES-1:0] sync_d;
  logic                   prev_q;
  logic                   prev_d;

  // Shift the raw input through the chain; remember last synchronized level
  always_comb begin
    sync_d = {sync_q[SYNC_STAGES-2:0], din};
    prev_d = sync_q[SYNC_STAGES-1];
  end

  // Synchronizer and history flops, preset high on reset
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      sync_q <= '1;
      prev_q <= 1'b1;
    end else begin
      sync_q <= sync_d;
      prev_q <= prev_d;
    end
  end

  assign dout = sync_q[SYNC_STAGES-1];
  assign rise = dout & ~prev_q;
  assign fall = ~dout & prev_q;

endmodule

// File: rtl/joy_db15_tx.sv
// DB15 joystick transmitter: serializes two 12-button players as a 24-bit active-low frame.
// Host drives joy_load (latch, active-low) and joy_clk (shift) asynchronously to clk;
// both are synchronized, and joy_data updates within SYNC_STAGES+1 clk cycles of a shift edge.
module joy_db15_tx
  import joy_db15_pkg::*;
#(
  parameter int SYNC_STAGES    = 2,
  parameter int TIMEOUT_CYCLES = 2_500_000
) (
  input  logic                clk,
  input  logic                reset,
  input  logic [BTN_BITS-1:0] joy1,
  input  logic [BTN_BITS-1:0] joy2,
  input  logic                joy_load,
  input  logic                joy_clk,
  output logic                joy_data,
  output logic                frame_done,
  output logic                host_active
);

  localparam int                 WD_W     = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [WD_W-1:0]    WD_MAX   = WD_W'(TIMEOUT_CYCLES);
  localparam logic [CNT_BITS-1:0] CNT_LAST = CNT_BITS'(FRAME_BITS);

  // Synchronized host signals
  logic load_s;
  logic load_rise;
  logic load_fall;
  logic clk_s;
  logic clk_rise;
  logic clk_fall;

  db15_sync_edge #(.SYNC_STAGES(SYNC_STAGES)) u_load_sync (
    .clk   (clk),
    .reset (reset),
    .din   (joy_load),
    .dout  (load_s),
    .rise  (load_rise),
    .fall  (load_fall)
  );

  db15_sync_edge #(.SYNC_STAGES(SYNC_STAGES)) u_clk_sync (
    .clk   (clk),
    .reset (reset),
    .din   (joy_clk),
    .dout  (clk_s),
    .rise  (clk_rise),
    .fall  (clk_fall)
  );

  // Latch is level-sensitive and shifting only needs rising edges
  logic unused_edges;
  assign unused_edges = &{1'b0, load_rise, load_fall, clk_s, clk_fall};

  // Frame state
  db15_state_t             state_q,      state_d;
  logic [FRAME_BITS-1:0]   shift_q,      shift_d;
  logic [CNT_BITS-1:0]     cnt_q,        cnt_d;
  logic                    joy_data_q,   joy_data_d;
  logic                    frame_done_q, frame_done_d;

  // Watchdog state
  logic [WD_W-1:0]         wd_q,          wd_d;
  logic                    host_active_q, host_active_d;

  // Next-state logic: latch strobe overrides everything, then per-state shifting
  always_comb begin
    state_d      = state_q;
    shift_d      = shift_q;
    cnt_d        = cnt_q;
    frame_done_d = 1'b0;

    if (!load_s) begin
      // Latch held: keep resampling the buttons, drop any partial frame
      state_d = ST_LOAD;
      shift_d = frame_word(joy1, joy2);
      cnt_d   = '0;
    end else begin
      unique case (state_q)
        ST_IDLE: begin
          state_d = ST_IDLE;
        end
        ST_LOAD: begin
          // Latch released: the snapshot from the last LOAD cycle is frozen
          state_d = ST_SHIFT;
        end
        ST_SHIFT: begin
          if (clk_rise) begin
            shift_d = {1'b1, shift_q[FRAME_BITS-1:1]};
            if (cnt_q < CNT_LAST) begin
              cnt_d = cnt_q + CNT_BITS'(1);
            end
            if (cnt_q == CNT_LAST - CNT_BITS'(1)) begin
              state_d      = ST_DONE;
              frame_done_d = 1'b1;
            end
          end
        end
        ST_DONE: begin
          state_d = ST_DONE;
        end
        default: begin
          state_d = ST_IDLE;
        end
      endcase
    end
  end

  // Output bit follows the register only while a frame is being presented
  always_comb begin
    if ((state_d == ST_LOAD) || (state_d == ST_SHIFT)) begin
      joy_data_d = shift_d[0];
    end else begin
      joy_data_d = 1'b1;
    end
  end

  // Watchdog: cleared by a completed frame, saturates at the timeout and drops host_active
  always_comb begin
    wd_d          = wd_q;
    host_active_d = host_active_q;
    if (frame_done_d) begin
      wd_d          = '0;
      host_active_d = 1'b1;
    end else begin
      if (wd_q != WD_MAX) begin
        wd_d = wd_q + WD_W'(1);
      end
      if (wd_d == WD_MAX) begin
        host_active_d = 1'b0;
      end
    end
  end

  // All state and outputs registered; reset aborts any frame immediately
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q       <= ST_IDLE;
      shift_q       <= '1;
      cnt_q         <= '0;
      joy_data_q    <= 1'b1;
      frame_done_q  <= 1'b0;
      wd_q          <= '0;
      host_active_q <= 1'b0;
    end else begin
      state_q       <= state_d;
      shift_q       <= shift_d;
      cnt_q         <= cnt_d;
      joy_data_q    <= joy_data_d;
      frame_done_q  <= frame_done_d;
      wd_q          <= wd_d;
      host_active_q <= host_active_d;
    end
  end

  assign joy_data    = joy_data_q;
  assign frame_done  = frame_done_q;
  assign host_active = host_active_q;

endmodule

// File: tb/tb_joy_db15_tx.sv
// Bench for joy_db15_tx: a host model drives latch/shift strobes and samples joy_data
// before each shift edge; expected bits come from the button-to-wire rule
// (pressed = 0, player 1 first, bit0 = Right, anything past bit 23 reads 1).
module tb_joy_db15_tx;

  localparam int SYNC = 2;
  localparam int TMO  = 100;
  localparam int HALF = 6;

  logic        clk      = 1'b0;
  logic        reset    = 1'b1;
  logic [11:0] joy1     = 12'h000;
  logic [11:0] joy2     = 12'h000;
  logic        joy_load = 1'b1;
  logic        joy_clk  = 1'b0;
  logic        joy_data;
  logic        frame_done;
  logic        host_active;

  int total    = 0;
  int bad      = 0;
  int fd_count = 0;

  joy_db15_tx #(.SYNC_STAGES(SYNC), .TIMEOUT_CYCLES(TMO)) dut (
    .clk         (clk),
    .reset       (reset),
    .joy1        (joy1),
    .joy2        (joy2),
    .joy_load    (joy_load),
    .joy_clk     (joy_clk),
    .joy_data    (joy_data),
    .frame_done  (frame_done),
    .host_active (host_active)
  );

  always #5 clk = ~clk;

  // Count every clk cycle in which frame_done is high
  always @(posedge clk) begin
    #2;
    if (frame_done === 1'b1) fd_count++;
  end

  // Reference: wire bit idx of a frame built from two button words
  function automatic logic exp_bit(input logic [11:0] j1, input logic [11:0] j2, input int idx);
    if (idx < 12) return ~j1[idx];
    if (idx < 24) return ~j2[idx - 12];
    return 1'b1;
  endfunction

  // Expected samples: index k is what the host sees after k shift edges
  function automatic logic [39:0] model_seq(input logic [11:0] j1, input logic [11:0] j2, input int n);
    logic [39:0] v;
    v = '1;
    for (int k = 0; k <= n; k++) v[k] = exp_bit(j1, j2, k);
    return v;
  endfunction

  task automatic cyc(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic do_load(input logic [11:0] j1, input logic [11:0] j2);
    joy1 = j1;
    joy2 = j2;
    joy_load = 1'b0;
    cyc(6);
    joy_load = 1'b1;
    cyc(6);
  endtask

  // Host shifting: sample data, then one full shift clock period, n times
  task automatic shift_bits(input int n, output logic [39:0] seen);
    seen = '1;
    for (int k = 0; k < n; k++) begin
      seen[k] = joy_data;
      joy_clk = 1'b1;
      cyc(HALF);
      joy_clk = 1'b0;
      cyc(HALF);
    end
    seen[n] = joy_data;
  endtask

  task automatic test_reset;
    cyc(2);
    total++; if (joy_data !== 1'b1) begin bad++; $display("FAIL reset_joy_data got=%b exp=1", joy_data); end
    total++; if (frame_done !== 1'b0) begin bad++; $display("FAIL reset_frame_done got=%b exp=0", frame_done); end
    total++; if (host_active !== 1'b0) begin bad++; $display("FAIL reset_host_active got=%b exp=0", host_active); end
    reset = 1'b0;
    cyc(4);
    total++; if (joy_data !== 1'b1) begin bad++; $display("FAIL idle_joy_data got=%b exp=1", joy_data); end
  endtask

  task automatic test_normal_frame;
    logic [39:0] seen;
    int fd0;
    fd0 = fd_count;
    do_load(12'h001, 12'h800);
    shift_bits(24, seen);
    cyc(4);
    total++; if (seen !== model_seq(12'h001, 12'h800, 24)) begin bad++; $display("FAIL normal_seq got=%h exp=%h", seen, model_seq(12'h001, 12'h800, 24)); end
    total++; if (seen[24:0] !== 25'h17FFFFE) begin bad++; $display("FAIL normal_pattern got=%h exp=17ffffe", seen[24:0]); end
    total++; if (fd_count - fd0 !== 1) begin bad++; $display("FAIL normal_frame_done got=%0d exp=1", fd_count - fd0); end
    total++; if (joy_data !== 1'b1) begin bad++; $display("FAIL normal_after got=%b exp=1", joy_data); end
    total++; if (host_active !== 1'b1) begin bad++; $display("FAIL normal_host_active got=%b exp=1", host_active); end
  endtask

  task automatic test_random_frames;
    logic [39:0] seen;
    logic [11:0] j1, j2;
    int n, fd0;
    for (int it = 0; it < 6; it++) begin
      j1 = 12'($urandom);
      j2 = 12'($urandom);
      n  = int'($urandom_range(24, 30));
      fd0 = fd_count;
      do_load(j1, j2);
      shift_bits(n, seen);
      cyc(4);
      total++; if (seen !== model_seq(j1, j2, n)) begin bad++; $display("FAIL rand_seq[%0d] got=%h exp=%h", it, seen, model_seq(j1, j2, n)); end
      total++; if (fd_count - fd0 !== 1) begin bad++; $display("FAIL rand_frame_done[%0d] got=%0d exp=1", it, fd_count - fd0); end
    end
  endtask

  task automatic test_abort;
    logic [39:0] seen;
    logic [11:0] j1, j2;
    int fd0;
    j1 = 12'($urandom);
    j2 = 12'($urandom);
    fd0 = fd_count;
    do_load(j1, j2);
    shift_bits(10, seen);
    total++; if (seen !== model_seq(j1, j2, 10)) begin bad++; $display("FAIL abort_partial got=%h exp=%h", seen, model_seq(j1, j2, 10)); end
    do_load(12'h002, j2);
    total++; if (fd_count - fd0 !== 0) begin bad++; $display("FAIL abort_no_done got=%0d exp=0", fd_count - fd0); end
    shift_bits(24, seen);
    cyc(4);
    total++; if (seen !== model_seq(12'h002, j2, 24)) begin bad++; $display("FAIL abort_next_seq got=%h exp=%h", seen, model_seq(12'h002, j2, 24)); end
    total++; if (seen[1] !== 1'b0) begin bad++; $display("FAIL abort_bit1 got=%b exp=0", seen[1]); end
    total++; if (fd_count - fd0 !== 1) begin bad++; $display("FAIL abort_frame_done got=%0d exp=1", fd_count - fd0); end
  endtask

  // Latch and shift edge together right before the 24th edge: only the latch may act
  task automatic test_simultaneous;
    logic [39:0] seen;
    logic [11:0] j1, j1n, j2;
    int fd0;
    j1  = 12'($urandom);
    j1n = 12'($urandom);
    j2  = 12'($urandom) | 12'h800;
    fd0 = fd_count;
    do_load(j1, j2);
    shift_bits(23, seen);
    joy1     = j1n;
    joy_clk  = 1'b1;
    joy_load = 1'b0;
    cyc(6);
    total++; if (fd_count - fd0 !== 0) begin bad++; $display("FAIL simul_no_done got=%0d exp=0", fd_count - fd0); end
    total++; if (joy_data !== exp_bit(j1n, j2, 0)) begin bad++; $display("FAIL simul_load_bit0 got=%b exp=%b", joy_data, exp_bit(j1n, j2, 0)); end
    joy_clk = 1'b0;
    cyc(HALF);
    joy_load = 1'b1;
    cyc(6);
    shift_bits(24, seen);
    cyc(4);
    total++; if (seen !== model_seq(j1n, j2, 24)) begin bad++; $display("FAIL simul_next_seq got=%h exp=%h", seen, model_seq(j1n, j2, 24)); end
    total++; if (fd_count - fd0 !== 1) begin bad++; $display("FAIL simul_frame_done got=%0d exp=1", fd_count - fd0); end
  endtask

  task automatic test_overrun;
    logic [39:0] seen;
    logic [11:0] j1, j2;
    int fd0;
    j1 = 12'($urandom);
    j2 = 12'($urandom);
    fd0 = fd_count;
    do_load(j1, j2);
    shift_bits(30, seen);
    cyc(4);
    total++; if (seen !== model_seq(j1, j2, 30)) begin bad++; $display("FAIL overrun_seq got=%h exp=%h", seen, model_seq(j1, j2, 30)); end
    total++; if (seen[30:24] !== 7'h7F) begin bad++; $display("FAIL overrun_tail got=%h exp=7f", seen[30:24]); end
    total++; if (fd_count - fd0 !== 1) begin bad++; $display("FAIL overrun_frame_done got=%0d exp=1", fd_count - fd0); end
  endtask

  task automatic test_watchdog;
    logic [39:0] seen;
    bit found;
    int n;
    do_load(12'($urandom), 12'($urandom));
    shift_bits(23, seen);
    joy_clk = 1'b1;
    found = 1'b0;
    for (int i = 0; i < 12; i++) begin
      @(negedge clk);
      if (frame_done === 1'b1) begin found = 1'b1; break; end
    end
    total++; if (found !== 1'b1) begin bad++; $display("FAIL wd_frame_done_seen got=%b exp=1", found); end
    total++; if (host_active !== 1'b1) begin bad++; $display("FAIL wd_active_at_done got=%b exp=1", host_active); end
    n = 1;
    for (int i = 0; i < 200; i++) begin
      @(negedge clk);
      if (host_active === 1'b1) n++;
      else break;
    end
    total++; if (n !== TMO) begin bad++; $display("FAIL wd_active_cycles got=%0d exp=%0d", n, TMO); end
    joy_clk = 1'b0;
    cyc(HALF);
  endtask

  task automatic test_reset_midframe;
    logic [39:0] seen;
    logic [11:0] j1, j2;
    logic all_ones;
    int fd0;
    j1 = 12'($urandom);
    j2 = 12'hFFF;
    fd0 = fd_count;
    do_load(j1, j2);
    shift_bits(12, seen);
    total++; if (seen !== model_seq(j1, j2, 12)) begin bad++; $display("FAIL rstmid_partial got=%h exp=%h", seen, model_seq(j1, j2, 12)); end
    #1 reset = 1'b1;
    #1;
    total++; if (joy_data !== 1'b1) begin bad++; $display("FAIL rstmid_joy_data got=%b exp=1", joy_data); end
    total++; if (host_active !== 1'b0) begin bad++; $display("FAIL rstmid_host_active got=%b exp=0", host_active); end
    cyc(3);
    reset = 1'b0;
    cyc(3);
    all_ones = 1'b1;
    for (int k = 0; k < 6; k++) begin
      joy_clk = 1'b1;
      cyc(HALF);
      all_ones &= joy_data;
      joy_clk = 1'b0;
      cyc(HALF);
      all_ones &= joy_data;
    end
    total++; if (all_ones !== 1'b1) begin bad++; $display("FAIL rstmid_clk_ignored got=%b exp=1", all_ones); end
    total++; if (fd_count - fd0 !== 0) begin bad++; $display("FAIL rstmid_no_done got=%0d exp=0", fd_count - fd0); end
    j1 = 12'($urandom);
    j2 = 12'($urandom);
    do_load(j1, j2);
    shift_bits(24, seen);
    cyc(4);
    total++; if (seen !== model_seq(j1, j2, 24)) begin bad++; $display("FAIL rstmid_fresh_seq got=%h exp=%h", seen, model_seq(j1, j2, 24)); end
    total++; if (fd_count - fd0 !== 1) begin bad++; $display("FAIL rstmid_fresh_done got=%0d exp=1", fd_count - fd0); end
  endtask

  initial begin
    test_reset();
    test_normal_frame();
    test_random_frames();
    test_abort();
    test_simultaneous();
    test_overrun();
    test_watchdog();
    test_reset_midframe();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
